// File: rtl/key_search_ctrl.sv
// Brute-force key search sequencer: walks candidate keys, drives the
// decryption pipeline for each, and scans the decrypted message for
// printable plaintext (space or lowercase letters only).
module key_search_ctrl #(
  parameter int unsigned MSG_DEP   = 32,
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_MAX   = 24'h3FFFFF,
  localparam int unsigned AW       = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          decrypt_done,
  input  logic [7:0]    msg_q,
  output logic          reset_pipeline,
  output logic          start_decrypt,
  output logic [23:0]   secret_key,
  output logic [AW-1:0] msg_address,
  output logic          busy,
  output logic          key_found,
  output logic          search_failed
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_DEP - 1);
  localparam logic [7:0]    CH_SPACE  = 8'd32;
  localparam logic [7:0]    CH_LO     = 8'd97;
  localparam logic [7:0]    CH_HI     = 8'd122;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RESET_PIPE,
    ST_START,
    ST_WAIT_DONE,
    ST_READ,
    ST_CHECK,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_FAIL
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [23:0]   key_nxt;
  logic [AW-1:0] addr_nxt;
  logic          byte_ok;

  // Plaintext character filter: space or a..z.
  always_comb begin
    byte_ok = (msg_q == CH_SPACE) || ((msg_q >= CH_LO) && (msg_q <= CH_HI));
  end

  // Next-state, next-key and next-address selection.
  always_comb begin
    state_nxt = state;
    key_nxt   = secret_key;
    addr_nxt  = msg_address;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          key_nxt   = KEY_START;
          state_nxt = ST_RESET_PIPE;
        end
      end
      ST_RESET_PIPE: state_nxt = ST_START;
      ST_START:      state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (decrypt_done) begin
          addr_nxt  = '0;
          state_nxt = ST_READ;
        end
      end
      ST_READ: state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!byte_ok) begin
          state_nxt = ST_NEXT_KEY;
        end else if (msg_address == LAST_ADDR) begin
          state_nxt = ST_FOUND;
        end else begin
          addr_nxt  = msg_address + AW'(1);
          state_nxt = ST_READ;
        end
      end
      ST_NEXT_KEY: begin
        // >= keeps the key from ever passing KEY_MAX even if misconfigured.
        if (secret_key >= KEY_MAX) begin
          state_nxt = ST_FAIL;
        end else begin
          key_nxt   = secret_key + 24'd1;
          state_nxt = ST_RESET_PIPE;
        end
      end
      ST_FOUND: state_nxt = ST_FOUND;
      ST_FAIL:  state_nxt = ST_FAIL;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state so
  // each output is high exactly while the FSM sits in the matching state.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      secret_key     <= KEY_START;
      msg_address    <= '0;
      reset_pipeline <= 1'b0;
      start_decrypt  <= 1'b0;
      busy           <= 1'b0;
      key_found      <= 1'b0;
      search_failed  <= 1'b0;
    end else begin
      state          <= state_nxt;
      secret_key     <= key_nxt;
      msg_address    <= addr_nxt;
      reset_pipeline <= (state_nxt == ST_RESET_PIPE);
      start_decrypt  <= (state_nxt == ST_START);
      busy           <= !((state_nxt == ST_IDLE) || (state_nxt == ST_FOUND) ||
                          (state_nxt == ST_FAIL));
      key_found      <= (state_nxt == ST_FOUND);
      search_failed  <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Scoreboard bench for key_search_ctrl: a per-key plan (position of the first
// bad byte, or DEP for an all-valid message) drives a memory model and a
// reference model that predicts the observable event stream.
module tb_key_search_ctrl;

  localparam int unsigned DEP     = 32;
  localparam logic [23:0] A_START = 24'h000000;
  localparam logic [23:0] A_MAX   = 24'h3FFFFF;
  localparam logic [23:0] B_START = 24'h3FFFFE;
  localparam logic [23:0] B_MAX   = 24'h3FFFFF;
  localparam int K_RP = 0, K_SD = 1, K_FOUND = 2, K_FAIL = 3;

  typedef struct {
    int          kind;
    logic [23:0] key;
    int          lat;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n, en_a, en_b, decrypt_done;
  logic [7:0]  msg_q;
  logic        rp_a, sd_a, busy_a, kf_a, sf_a;
  logic        rp_b, sd_b, busy_b, kf_b, sf_b;
  logic [23:0] key_a, key_b;
  logic [4:0]  addr_a, addr_b;
  logic        sel;

  logic        m_rp, m_sd, m_busy, m_kf, m_sf;
  logic [23:0] m_key;
  logic [4:0]  m_addr;
  assign m_rp   = sel ? rp_b   : rp_a;
  assign m_sd   = sel ? sd_b   : sd_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_kf   = sel ? kf_b   : kf_a;
  assign m_sf   = sel ? sf_b   : sf_a;
  assign m_key  = sel ? key_b  : key_a;
  assign m_addr = sel ? addr_b : addr_a;

  key_search_ctrl #(.MSG_DEP(DEP), .KEY_START(A_START), .KEY_MAX(A_MAX)) dut_a (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(en_a), .decrypt_done(decrypt_done),
    .msg_q(msg_q), .reset_pipeline(rp_a), .start_decrypt(sd_a), .secret_key(key_a),
    .msg_address(addr_a), .busy(busy_a), .key_found(kf_a), .search_failed(sf_a));

  key_search_ctrl #(.MSG_DEP(DEP), .KEY_START(B_START), .KEY_MAX(B_MAX)) dut_b (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(en_b), .decrypt_done(decrypt_done),
    .msg_q(msg_q), .reset_pipeline(rp_b), .start_decrypt(sd_b), .secret_key(key_b),
    .msg_address(addr_b), .busy(busy_b), .key_found(kf_b), .search_failed(sf_b));

  int          checks = 0, failures = 0;
  int          cyc = 0, t_done = 0, done_cnt = 0, cnt = 0;
  bit          noise = 1'b0, force_a = 1'b0;
  int          fixed_bad = -1;
  logic [23:0] cur_start = 24'h0;
  int          plan[$];
  ev_t         exp_q[$];
  logic [23:0] exp_final_key;
  bit          exp_found;
  bit          prev_kf, prev_sf;
  logic [7:0]  valid_tab[4];
  logic [7:0]  bad_tab[6];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Message memory: first bad byte at plan position, valid bytes elsewhere.
  function automatic logic [7:0] mem_byte(input logic [23:0] k, input logic [4:0] a);
    int idx = int'(k) - int'(cur_start);
    int bad = 0;
    if (idx >= 0 && idx < plan.size()) bad = plan[idx];
    if (int'(a) == bad)
      return (fixed_bad >= 0) ? 8'(fixed_bad) : bad_tab[(int'(k) + int'(a)) % 6];
    return force_a ? 8'h61 : valid_tab[(int'(k) * 3 + int'(a)) % 4];
  endfunction

  always @(posedge clk) msg_q <= mem_byte(m_key, m_addr);

  function automatic string kname(input int k);
    case (k)
      K_RP:    return "reset_pipeline";
      K_SD:    return "start_decrypt";
      K_FOUND: return "key_found";
      default: return "search_failed";
    endcase
  endfunction

  function automatic void push_ev(input int kind, input logic [23:0] key, input int lat);
    ev_t e;
    e.kind = kind;
    e.key  = key;
    e.lat  = lat;
    exp_q.push_back(e);
  endfunction

  // Reference model: candidate loop over the plan, latencies counted from the
  // cycle decrypt_done is accepted (2 cycles per byte read, +1 to move on).
  task automatic build_exp(input logic [23:0] ks, input logic [23:0] km);
    int lat = -1;
    logic [23:0] k;
    exp_q.delete();
    for (int i = 0; i < plan.size(); i++) begin
      k = ks + 24'(i);
      push_ev(K_RP, k, lat);
      push_ev(K_SD, k, -1);
      exp_final_key = k;
      if (plan[i] >= int'(DEP)) begin
        exp_found = 1'b1;
        push_ev(K_FOUND, k, 2 * int'(DEP));
        return;
      end
      lat = 2 * (plan[i] + 1) + 1;
      if (k == km) begin
        exp_found = 1'b0;
        push_ev(K_FAIL, k, lat);
        return;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  // Scoreboard compare for one observed output event.
  task automatic observe(input int kind);
    ev_t e;
    int  lat;
    bit  exp_busy, bad;
    lat = cyc - t_done;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event_%s: unexpected event key=%h busy=%0d, none expected",
               kname(kind), m_key, m_busy);
    end else begin
      e = exp_q.pop_front();
      exp_busy = (kind < K_FOUND);
      bad = (e.kind != kind) || (e.key !== m_key) || (e.lat >= 0 && e.lat != lat) ||
            (m_busy !== exp_busy) || (kind == K_FOUND && m_sf !== 1'b0) ||
            (kind == K_FAIL && m_kf !== 1'b0);
      if (bad) begin
        failures++;
        $display("FAIL event_%s: got key=%h lat=%0d busy=%0d kf=%0d sf=%0d, expected %s key=%h lat=%0d busy=%0d",
                 kname(kind), m_key, lat, m_busy, m_kf, m_sf, kname(e.kind), e.key, e.lat, exp_busy);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever an output event appears.
  initial begin
    prev_kf = 1'b0;
    prev_sf = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (m_rp === 1'b1) observe(K_RP);
        if (m_sd === 1'b1) observe(K_SD);
        if (m_kf === 1'b1 && !prev_kf) observe(K_FOUND);
        if (m_sf === 1'b1 && !prev_sf) observe(K_FAIL);
      end
      prev_kf = (m_kf === 1'b1);
      prev_sf = (m_sf === 1'b1);
    end
  end

  // Decryption pipeline model plus optional stray decrypt_done pulses.
  initial begin
    decrypt_done = 1'b0;
    forever begin
      @(negedge clk);
      decrypt_done = 1'b0;
      if (reset_n !== 1'b1) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          decrypt_done = 1'b1;
          t_done = cyc + 1;
          done_cnt++;
        end
      end else if (m_sd === 1'b1) begin
        cnt = int'($urandom_range(1, 4));
      end else if (noise && $urandom_range(0, 5) == 0) begin
        decrypt_done = 1'b1;
      end
    end
  end

  task automatic set_en(input bit v);
    if (sel) en_b = v;
    else     en_a = v;
  endtask

  // Called on a negedge; asserts reset and checks outputs immediately.
  task automatic do_reset();
    en_a = 1'b0;
    en_b = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_outputs", 32'({m_rp, m_sd, m_busy, m_kf, m_sf}), 32'd0);
    chk("rst_key", 32'(m_key), 32'(sel ? B_START : A_START));
    chk("rst_addr", 32'(m_addr), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic go(input bit toggle);
    int n = 0;
    build_exp(cur_start, sel ? B_MAX : A_MAX);
    @(negedge clk);
    set_en(1'b1);
    @(negedge clk);
    while (!(m_kf === 1'b1 || m_sf === 1'b1) && n < 5000) begin
      if (toggle) set_en(1'($urandom_range(0, 1)));
      @(negedge clk);
      n++;
    end
    set_en(1'b0);
    chk("terminal_reached", 32'(m_kf === 1'b1 || m_sf === 1'b1), 32'd1);
    @(negedge clk);
    set_en(1'b1);
    repeat (4) @(negedge clk);
    set_en(1'b0);
    repeat (4) @(negedge clk);
    chk("final_flags", 32'({m_kf, m_sf, m_busy}), exp_found ? 32'd4 : 32'd2);
    chk("final_key", 32'(m_key), 32'(exp_final_key));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_search(input bit b, input bit toggle);
    sel = b;
    cur_start = b ? B_START : A_START;
    @(negedge clk);
    do_reset();
    go(toggle);
  endtask

  // Reset during WAIT_DONE (in_check=0) or during the third CHECK (in_check=1).
  task automatic reset_mid(input bit in_check);
    int n = 0;
    int base;
    sel = 1'b0;
    cur_start = A_START;
    @(negedge clk);
    do_reset();
    plan = {int'(DEP)};
    build_exp(A_START, A_MAX);
    base = done_cnt;
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    if (!in_check) begin
      while (m_sd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("saw_start", 32'(m_sd), 32'd1);
      @(negedge clk);
    end else begin
      while (done_cnt == base && n < 50) begin @(negedge clk); n++; end
      chk("saw_done", 32'(done_cnt != base), 32'd1);
      while (cyc < t_done + 5 && n < 100) begin @(negedge clk); n++; end
      chk("addr_in_check", 32'(m_addr), 32'd2);
    end
    do_reset();
    repeat (8) @(negedge clk);
    chk("idle_after_reset", 32'({m_busy, m_kf, m_sf, m_addr}), 32'd0);
    chk("idle_key", 32'(m_key), 32'(A_START));
    plan = {2, int'(DEP)};
    go(1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    valid_tab = '{8'd32, 8'd97, 8'd122, 8'd109};
    bad_tab   = '{8'd96, 8'd123, 8'h41, 8'd31, 8'd64, 8'hFF};
    reset_n = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    sel = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    do_reset();

    force_a = 1'b1;
    plan = {int'(DEP)};
    run_search(1'b0, 1'b0);
    force_a = 1'b0;

    fixed_bad = 8'h41;
    plan = {0, 0, 0, int'(DEP)};
    run_search(1'b0, 1'b0);
    fixed_bad = -1;

    noise = 1'b1;
    plan = {31, int'(DEP)};
    run_search(1'b0, 1'b1);

    plan = {int'($urandom_range(0, 31)), int'($urandom_range(0, 31))};
    run_search(1'b1, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int n;
      plan.delete();
      n = int'($urandom_range(0, 4));
      for (int j = 0; j < n; j++) plan.push_back(int'($urandom_range(0, 31)));
      plan.push_back(int'(DEP));
      run_search(1'b0, 1'b1);
    end

    reset_mid(1'b0);
    reset_mid(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
